// File: rtl/ppu_vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_pkg
// Brief    : Shared requester ids, mirroring encoding and VRAM region bases
// Revision : 1.0 - initial release
// ============================================================================
package ppu_vram_pkg;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_RND = 2'd0;
    localparam req_id_t REQ_COL = 2'd1;
    localparam req_id_t REQ_CPU = 2'd2;

    localparam logic MIRROR_HORZ = 1'b0;
    localparam logic MIRROR_VERT = 1'b1;

    localparam logic [15:0] PALETTE_BASE = 16'h3F00;
    localparam logic [15:0] NT_BASE      = 16'h2000;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/ppu_vram_addr_map.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_addr_map
// Brief    : Combinational PPU address mirroring (palette, nametable, $3xxx alias)
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_addr_map
    import ppu_vram_pkg::*;
(
    input  logic [15:0] addr,
    input  logic        mirror_vert,
    output logic [15:0] mapped
);

    logic [13:0] w_a;
    logic [13:0] w_nt;
    logic        w_unused_hi;

    assign w_unused_hi = ^addr[15:14];

    always_comb begin
        w_a    = addr[13:0];
        w_nt   = w_a;
        mapped = {2'b00, w_a};
        if (w_a >= PALETTE_BASE[13:0]) begin
            mapped = PALETTE_BASE | {11'd0, w_a[4:0]};
            // Sprite palette entry 0 of each group aliases the background entry
            if (w_a[4] && (w_a[1:0] == 2'b00)) begin
                mapped[4] = 1'b0;
            end
        end else if (w_a >= NT_BASE[13:0]) begin
            w_nt = {2'b10, w_a[11:0]};
            if (mirror_vert == MIRROR_HORZ) begin
                w_nt[10] = w_nt[11];
            end
            w_nt[11] = 1'b0;
            mapped   = {2'b00, w_nt};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_arbiter
// Brief    : Three-way VRAM port arbiter with mirroring and tagged read return
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_arbiter
    import ppu_vram_pkg::*;
#(
    parameter int RD_LAT       = 1,
    parameter int CPU_MAX_WAIT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mirror_vert,
    input  logic        rnd_req,
    input  logic [15:0] rnd_addr,
    output logic        rnd_gnt,
    output logic        rnd_rvalid,
    input  logic        col_req,
    input  logic [15:0] col_addr,
    output logic        col_gnt,
    output logic        col_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  rdata,
    output logic [15:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic        busy
);

    localparam int WAIT_W = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    logic [WAIT_W-1:0] r_cpu_wait;
    logic              w_cpu_first;
    logic              w_rnd_gnt;
    logic              w_col_gnt;
    logic              w_cpu_gnt;
    logic              w_any_gnt;
    logic [15:0]       w_sel_addr;
    logic [15:0]       w_map_addr;
    tag_t              w_new_tag;
    tag_t              r_tag [RD_LAT+1];
    logic              w_tag_busy;

    logic [15:0]       r_vram_addr;
    logic              r_vram_we;
    logic [7:0]        r_vram_wdata;
    logic [7:0]        r_rdata;
    logic              r_rnd_rvalid;
    logic              r_col_rvalid;
    logic              r_cpu_rvalid;

    // Grants are held off during reset so nothing is issued in that cycle
    always_comb begin
        w_cpu_first = (r_cpu_wait >= WAIT_MAX);
        w_rnd_gnt   = 1'b0;
        w_col_gnt   = 1'b0;
        w_cpu_gnt   = 1'b0;
        if (!rst) begin
            if (w_cpu_first && cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (rnd_req) begin
                w_rnd_gnt = 1'b1;
            end else if (col_req) begin
                w_col_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt  = w_rnd_gnt | w_col_gnt | w_cpu_gnt;
    assign w_sel_addr = w_cpu_gnt ? cpu_addr : (w_col_gnt ? col_addr : rnd_addr);

    ppu_vram_addr_map u_addr_map (
        .addr        (w_sel_addr),
        .mirror_vert (mirror_vert),
        .mapped      (w_map_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_wait <= '0;
        end else if (w_cpu_gnt) begin
            r_cpu_wait <= '0;
        end else if (cpu_req && (r_cpu_wait != WAIT_MAX)) begin
            r_cpu_wait <= r_cpu_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vram_addr  <= '0;
            r_vram_we    <= 1'b0;
            r_vram_wdata <= '0;
        end else begin
            r_vram_we <= w_cpu_gnt & cpu_we;
            if (w_any_gnt) begin
                r_vram_addr <= w_map_addr;
            end
            if (w_cpu_gnt && cpu_we) begin
                r_vram_wdata <= cpu_wdata;
            end
        end
    end

    always_comb begin
        w_new_tag.valid = w_any_gnt & ~(w_cpu_gnt & cpu_we);
        w_new_tag.id    = w_cpu_gnt ? REQ_CPU : (w_col_gnt ? REQ_COL : REQ_RND);
    end

    // Stage k holds the read whose address went out k+1 cycles ago
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_new_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        w_tag_busy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            w_tag_busy = w_tag_busy | r_tag[i].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata      <= '0;
            r_rnd_rvalid <= 1'b0;
            r_col_rvalid <= 1'b0;
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_rnd_rvalid <= r_tag[RD_LAT].valid && (r_tag[RD_LAT].id == REQ_RND);
            r_col_rvalid <= r_tag[RD_LAT].valid && (r_tag[RD_LAT].id == REQ_COL);
            r_cpu_rvalid <= r_tag[RD_LAT].valid && (r_tag[RD_LAT].id == REQ_CPU);
            if (r_tag[RD_LAT].valid) begin
                r_rdata <= vram_rdata;
            end
        end
    end

    assign rnd_gnt    = w_rnd_gnt;
    assign col_gnt    = w_col_gnt;
    assign cpu_gnt    = w_cpu_gnt;
    assign rnd_rvalid = r_rnd_rvalid;
    assign col_rvalid = r_col_rvalid;
    assign cpu_rvalid = r_cpu_rvalid;
    assign rdata      = r_rdata;
    assign vram_addr  = r_vram_addr;
    assign vram_we    = r_vram_we;
    assign vram_wdata = r_vram_wdata;
    assign busy       = ~rst & (w_tag_busy | w_any_gnt);

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_vram_arbiter
// Brief    : Directed, table-driven checks of arbitration, mapping and read return
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_arbiter;

    localparam int RD_LAT       = 1;
    localparam int CPU_MAX_WAIT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        mirror_vert;
    logic        rnd_req, col_req, cpu_req, cpu_we;
    logic [15:0] rnd_addr, col_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        rnd_gnt, col_gnt, cpu_gnt;
    logic        rnd_rvalid, col_rvalid, cpu_rvalid;
    logic [7:0]  rdata;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        busy;

    ppu_vram_arbiter #(
        .RD_LAT       (RD_LAT),
        .CPU_MAX_WAIT (CPU_MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mirror_vert (mirror_vert),
        .rnd_req     (rnd_req),
        .rnd_addr    (rnd_addr),
        .rnd_gnt     (rnd_gnt),
        .rnd_rvalid  (rnd_rvalid),
        .col_req     (col_req),
        .col_addr    (col_addr),
        .col_gnt     (col_gnt),
        .col_rvalid  (col_rvalid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .rdata       (rdata),
        .vram_addr   (vram_addr),
        .vram_we     (vram_we),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // VRAM model: one-cycle synchronous read; unwritten bytes follow a fixed pattern
    logic [7:0] mem     [0:65535];
    bit         written [0:65535];

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr]     <= vram_wdata;
            written[vram_addr] <= 1'b1;
        end
        vram_rdata <= written[vram_addr] ? mem[vram_addr] : dflt(vram_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] gnts();
        return {rnd_gnt, col_gnt, cpu_gnt};
    endfunction

    function automatic logic [2:0] rvs();
        return {rnd_rvalid, col_rvalid, cpu_rvalid};
    endfunction

    task automatic idle();
        rnd_req = 1'b0;
        col_req = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    typedef struct {
        logic        mirror;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [15:0] exp;
    } map_vec_t;

    map_vec_t vecs [18];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gnt_at;

        vecs[0]  = '{1'b1, 1'b1, 16'h3F10, 8'h21, 16'h3F00};
        vecs[1]  = '{1'b1, 1'b0, 16'h3F14, 8'h00, 16'h3F04};
        vecs[2]  = '{1'b0, 1'b0, 16'h3F18, 8'h00, 16'h3F08};
        vecs[3]  = '{1'b1, 1'b1, 16'h3F1C, 8'h33, 16'h3F0C};
        vecs[4]  = '{1'b1, 1'b0, 16'h3F04, 8'h00, 16'h3F04};
        vecs[5]  = '{1'b1, 1'b0, 16'h3F25, 8'h00, 16'h3F05};
        vecs[6]  = '{1'b0, 1'b0, 16'h3F30, 8'h00, 16'h3F00};
        vecs[7]  = '{1'b1, 1'b0, 16'h3FFF, 8'h00, 16'h3F1F};
        vecs[8]  = '{1'b0, 1'b0, 16'h2C05, 8'h00, 16'h2405};
        vecs[9]  = '{1'b1, 1'b0, 16'h2C05, 8'h00, 16'h2405};
        vecs[10] = '{1'b1, 1'b0, 16'h2805, 8'h00, 16'h2005};
        vecs[11] = '{1'b0, 1'b0, 16'h2805, 8'h00, 16'h2405};
        vecs[12] = '{1'b0, 1'b0, 16'h2405, 8'h00, 16'h2005};
        vecs[13] = '{1'b1, 1'b0, 16'h2405, 8'h00, 16'h2405};
        vecs[14] = '{1'b1, 1'b0, 16'h3123, 8'h00, 16'h2123};
        vecs[15] = '{1'b0, 1'b0, 16'h3EFF, 8'h00, 16'h26FF};
        vecs[16] = '{1'b1, 1'b0, 16'hC123, 8'h00, 16'h0123};
        vecs[17] = '{1'b0, 1'b0, 16'h1FFF, 8'h00, 16'h1FFF};

        rst = 1'b1;
        mirror_vert = 1'b1;
        rnd_addr = '0; col_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        idle();
        repeat (3) cyc();

        // Reset state
        rst = 1'b0;
        @(negedge clk);
        chk("reset_gnt",        gnts(),     3'b000);
        chk("reset_rvalid",     rvs(),      3'b000);
        chk("reset_rdata",      rdata,      8'h00);
        chk("reset_vram_addr",  vram_addr,  16'h0000);
        chk("reset_vram_we",    vram_we,    1'b0);
        chk("reset_vram_wdata", vram_wdata, 8'h00);
        chk("reset_busy",       busy,       1'b0);

        // Single render read
        cyc(); rnd_req = 1'b1; rnd_addr = 16'h0123;
        @(negedge clk);
        chk("single_gnt",  gnts(), 3'b100);
        chk("single_busy", busy,   1'b1);
        cyc(); rnd_req = 1'b0;
        @(negedge clk);
        chk("single_vram_addr", vram_addr, 16'h0123);
        chk("single_vram_we",   vram_we,   1'b0);
        chk("single_rv_t1",     rvs(),     3'b000);
        cyc(); @(negedge clk);
        chk("single_rv_t2", rvs(), 3'b000);
        cyc(); @(negedge clk);
        chk("single_rv_t3", rvs(), 3'b100);
        chk("single_rdata", rdata, 8'h5A);
        cyc(); @(negedge clk);
        chk("single_rv_t4", rvs(), 3'b000);

        // Three simultaneous requesters, default order
        cyc();
        rnd_req = 1'b1; rnd_addr = 16'h0123;
        col_req = 1'b1; col_addr = 16'h3F01;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
        @(negedge clk);
        chk("tri_gnt_t0", gnts(), 3'b100);
        cyc(); rnd_req = 1'b0;
        @(negedge clk);
        chk("tri_gnt_t1", gnts(), 3'b010);
        cyc(); col_req = 1'b0;
        @(negedge clk);
        chk("tri_gnt_t2", gnts(), 3'b001);
        cyc(); cpu_req = 1'b0;
        @(negedge clk);
        chk("tri_rv_t3",    rvs(), 3'b100);
        chk("tri_rdata_t3", rdata, 8'h5A);
        cyc(); @(negedge clk);
        chk("tri_rv_t4",    rvs(), 3'b010);
        chk("tri_rdata_t4", rdata, 8'h46);
        cyc(); @(negedge clk);
        chk("tri_rv_t5",    rvs(), 3'b001);
        chk("tri_rdata_t5", rdata, 8'h68);

        // Address mapping table, issued through the cpu port
        for (int i = 0; i < 18; i++) begin
            cyc();
            mirror_vert = vecs[i].mirror;
            cpu_req   = 1'b1;
            cpu_we    = vecs[i].we;
            cpu_addr  = vecs[i].addr;
            cpu_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("map%0d_gnt", i), cpu_gnt, 1'b1);
            cyc(); idle();
            @(negedge clk);
            chk($sformatf("map%0d_addr", i), vram_addr, vecs[i].exp);
            chk($sformatf("map%0d_we", i),   vram_we,   vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("map%0d_wdata", i), vram_wdata, vecs[i].wdata);
            end
        end
        repeat (3) cyc();

        // Cpu starvation against a continuous render stream
        cyc();
        mirror_vert = 1'b1;
        rnd_req = 1'b1; rnd_addr = 16'h0040;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0041;
        gnt_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (k != 0) cyc();
            @(negedge clk);
            if (cpu_gnt) begin
                gnt_at = k;
                break;
            end
        end
        chk("starve_gnt_cycle",   gnt_at,  CPU_MAX_WAIT);
        chk("starve_rnd_blocked", rnd_gnt, 1'b0);
        cyc();
        @(negedge clk);
        chk("starve_wait_cleared", gnts(), 3'b100);
        cyc(); idle();
        repeat (4) cyc();

        // Cpu write followed by render read of the same physical byte
        cyc();
        mirror_vert = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2005; cpu_wdata = 8'h77;
        @(negedge clk);
        chk("raw_cpu_gnt", gnts(), 3'b001);
        cyc();
        cpu_req = 1'b0; cpu_we = 1'b0;
        rnd_req = 1'b1; rnd_addr = 16'h2005;
        @(negedge clk);
        chk("raw_rnd_gnt",   gnts(),    3'b100);
        chk("raw_vram_we",   vram_we,   1'b1);
        chk("raw_vram_addr", vram_addr, 16'h2005);
        cyc(); rnd_req = 1'b0;
        @(negedge clk);
        chk("raw_rv_t2", rvs(), 3'b000);
        cyc(); @(negedge clk);
        chk("raw_rv_t3", rvs(), 3'b000);
        cyc(); @(negedge clk);
        chk("raw_rv_t4", rvs(), 3'b100);
        chk("raw_rdata", rdata, 8'h77);

        // Reset while two reads are in flight
        cyc(); rnd_req = 1'b1; rnd_addr = 16'h0200;
        @(negedge clk);
        chk("rst_rnd_gnt", gnts(), 3'b100);
        cyc(); rnd_req = 1'b0; col_req = 1'b1; col_addr = 16'h0300;
        @(negedge clk);
        chk("rst_col_gnt", gnts(), 3'b010);
        cyc();
        col_req = 1'b0; rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 8'hEE;
        @(negedge clk);
        chk("rst_no_gnt",  gnts(), 3'b000);
        chk("rst_busy_in", busy,   1'b0);
        cyc(); rst = 1'b0; idle();
        @(negedge clk);
        chk("rst_rv_t3",   rvs(),   3'b000);
        chk("rst_we_t3",   vram_we, 1'b0);
        chk("rst_busy_t3", busy,    1'b0);
        chk("rst_rdata",   rdata,   8'h00);
        cyc(); @(negedge clk);
        chk("rst_rv_t4", rvs(), 3'b000);
        cyc(); rnd_req = 1'b1; rnd_addr = 16'h0123;
        @(negedge clk);
        chk("post_rst_gnt", gnts(), 3'b100);
        cyc(); rnd_req = 1'b0;
        cyc();
        cyc(); @(negedge clk);
        chk("post_rst_rv",    rvs(), 3'b100);
        chk("post_rst_rdata", rdata, 8'h5A);

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
